// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the coordinate type used by the sync generator,
// the renderer and the paddle/ball movers.
package vga_pkg;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   // Half-open interval test [lo, hi) on screen coordinates.
   function automatic logic in_span(input coord_t val, input coord_t lo, input coord_t hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_tick_divider.sv
// Modulo-N free-running counter with a one-clk pulse on its terminal count.
module tick_divider #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int          W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Gated so the pulse is suppressed in the very cycle reset is raised.
   assign tick = (cnt_q == LAST) && !reset;

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel/line counters, registered sync and
// blanking decode, plus pixel-enable, frame and 1 ms game ticks.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = vga_pkg::DEF_H_DISPLAY,
   parameter int H_FRONT   = vga_pkg::DEF_H_FRONT,
   parameter int H_SYNC    = vga_pkg::DEF_H_SYNC,
   parameter int H_BACK    = vga_pkg::DEF_H_BACK,
   parameter int V_DISPLAY = vga_pkg::DEF_V_DISPLAY,
   parameter int V_FRONT   = vga_pkg::DEF_V_FRONT,
   parameter int V_SYNC    = vga_pkg::DEF_V_SYNC,
   parameter int V_BACK    = vga_pkg::DEF_V_BACK,
   parameter int CLK_HZ    = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       p_tick,
   output logic       frame_tick,
   output logic       clk_1ms
);

   localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
   localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
   localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
   localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
   localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
   localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

   coord_t h_q, h_d;
   coord_t v_q, v_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;
   logic   video_on_q, video_on_d;

   tick_divider #(.N(CLK_DIV)) u_pix_div (
      .clk   (clk),
      .reset (reset),
      .tick  (p_tick)
   );

   tick_divider #(.N(CLK_HZ / 1000)) u_ms_div (
      .clk   (clk),
      .reset (reset),
      .tick  (clk_1ms)
   );

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (p_tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Decoding the next-state counts keeps the registered syncs aligned with x/y.
   always_comb begin
      hsync_d    = !in_span(h_d, HS_START, HS_END);
      vsync_d    = !in_span(v_d, VS_START, VS_END);
      video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q        <= '0;
         v_q        <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
      end else begin
         h_q        <= h_d;
         v_q        <= v_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

   assign x          = h_q;
   assign y          = v_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = video_on_q;
   assign frame_tick = p_tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster so whole frames fit in a short run;
// expectations come from an arithmetic model indexed by clocks since reset release.
module tb_vga_sync_gen;

   localparam int CD     = 4;
   localparam int HD     = 64;
   localparam int HF     = 8;
   localparam int HS     = 12;
   localparam int HB     = 6;
   localparam int VD     = 24;
   localparam int VF     = 3;
   localparam int VS     = 2;
   localparam int VB     = 4;
   localparam int CLK_HZ = 1000000;
   localparam int HT     = HD + HF + HS + HB;
   localparam int VT     = VD + VF + VS + VB;
   localparam int MS     = CLK_HZ / 1000;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       pt;
      logic       ft;
      logic       ms;
   } snap_t;

   localparam snap_t RST_SNAP = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1,
                                  vo: 1'b0, pt: 1'b0, ft: 1'b0, ms: 1'b0};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hsync, vsync, video_on, p_tick, frame_tick, clk_1ms;
   logic [9:0] x, y;

   int unsigned k = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   vga_sync_gen #(
      .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_HZ(CLK_HZ)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .hsync      (hsync),
      .vsync      (vsync),
      .video_on   (video_on),
      .x          (x),
      .y          (y),
      .p_tick     (p_tick),
      .frame_tick (frame_tick),
      .clk_1ms    (clk_1ms)
   );

   always #5 clk = ~clk;

   // Clocks elapsed since the last edge that sampled reset high.
   always @(posedge clk) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   // Reference: after kk released clocks, kk/CD pixels have elapsed in raster order.
   function automatic snap_t model(input int unsigned kk);
      int unsigned pix = kk / CD;
      int unsigned h   = pix % HT;
      int unsigned v   = (pix / HT) % VT;
      snap_t s;
      s.x  = 10'(h);
      s.y  = 10'(v);
      s.pt = ((kk % CD) == CD - 1);
      s.hs = !((h >= HD + HF) && (h < HD + HF + HS));
      s.vs = !((v >= VD + VF) && (v < VD + VF + VS));
      s.vo = (kk >= 1) && (h < HD) && (v < VD);
      s.ft = s.pt && (h == HT - 1) && (v == VT - 1);
      s.ms = ((kk % MS) == MS - 1);
      return s;
   endfunction

   function automatic snap_t observe();
      snap_t s;
      s.x  = x;
      s.y  = y;
      s.hs = hsync;
      s.vs = vsync;
      s.vo = video_on;
      s.pt = p_tick;
      s.ft = frame_tick;
      s.ms = clk_1ms;
      return s;
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ft=%b ms=%b",
                       s.x, s.y, s.hs, s.vs, s.vo, s.pt, s.ft, s.ms);
   endfunction

   task automatic test_reset();
      snap_t o, e;
      reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         o = observe();
         n_cmp++;
         if (o !== RST_SNAP) begin
            n_bad++;
            $display("FAIL reset_hold: actual %s required %s", fmt(o), fmt(RST_SNAP));
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         o = observe();
         e = model(k);
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL cadence k=%0d: actual %s required %s", k, fmt(o), fmt(e));
         end
         n_cmp++;
         if (p_tick !== ((i % 4) == 3)) begin
            n_bad++;
            $display("FAIL p_tick_clk%0d: actual %b required %b", i, p_tick, (i % 4) == 3);
         end
         if (i == 4) begin
            n_cmp++;
            if (x !== 10'd1) begin
               n_bad++;
               $display("FAIL first_x_step: actual %0d required 1", x);
            end
         end
      end
   endtask

   task automatic test_horizontal();
      snap_t o, e;
      int    n  = CD * (HT + 2) - int'(k);
      int    px = int'(x);
      int    py = int'(y);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         o = observe();
         e = model(k);
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL hline k=%0d: actual %s required %s", k, fmt(o), fmt(e));
         end
         if (int'(o.x) != px) begin
            if (o.x == HD + HF) begin
               n_cmp++;
               if (o.hs !== 1'b0) begin
                  n_bad++;
                  $display("FAIL hsync_fall: actual %b required 0", o.hs);
               end
            end
            if (o.x == HD + HF + HS) begin
               n_cmp++;
               if (o.hs !== 1'b1) begin
                  n_bad++;
                  $display("FAIL hsync_rise: actual %b required 1", o.hs);
               end
            end
            if (o.x == HD) begin
               n_cmp++;
               if (o.vo !== 1'b0) begin
                  n_bad++;
                  $display("FAIL video_off_x: actual %b required 0", o.vo);
               end
            end
         end
         if (py == 0 && o.y == 10'd1) begin
            n_cmp++;
            if (o.x !== 10'd0 || px != HT - 1) begin
               n_bad++;
               $display("FAIL line_wrap: actual x=%0d prev_x=%0d required x=0 prev_x=%0d",
                        o.x, px, HT - 1);
            end
         end
         px = int'(o.x);
         py = int'(o.y);
      end
   endtask

   task automatic test_frame();
      snap_t o, e;
      int    ft_count = 0;
      bit    ft_prev  = 1'b0;
      for (int i = 0; i < CD * HT * VT + 8; i++) begin
         @(negedge clk);
         o = observe();
         e = model(k);
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL frame k=%0d: actual %s required %s", k, fmt(o), fmt(e));
         end
         if (o.vs === 1'b0) begin
            n_cmp++;
            if (!(o.y >= VD + VF && o.y < VD + VF + VS)) begin
               n_bad++;
               $display("FAIL vsync_line: vsync low at y=%0d required y in %0d..%0d",
                        o.y, VD + VF, VD + VF + VS - 1);
            end
         end
         if (o.y >= VD) begin
            n_cmp++;
            if (o.vo !== 1'b0) begin
               n_bad++;
               $display("FAIL vblank_video: actual %b required 0 at y=%0d", o.vo, o.y);
            end
         end
         if (ft_prev) begin
            n_cmp++;
            if (o.x !== 10'd0 || o.y !== 10'd0) begin
               n_bad++;
               $display("FAIL frame_wrap: actual x=%0d y=%0d required 0 0", o.x, o.y);
            end
         end
         if (o.ft === 1'b1) begin
            ft_count++;
            n_cmp++;
            if (o.x !== 10'(HT - 1) || o.y !== 10'(VT - 1)) begin
               n_bad++;
               $display("FAIL frame_tick_pos: actual x=%0d y=%0d required %0d %0d",
                        o.x, o.y, HT - 1, VT - 1);
            end
         end
         ft_prev = (o.ft === 1'b1);
      end
      n_cmp++;
      if (ft_count != 1) begin
         n_bad++;
         $display("FAIL frame_tick_count: actual %0d required 1", ft_count);
      end
   endtask

   task automatic test_ms();
      snap_t       o, e;
      int unsigned hits[$];
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2 * MS + 5; i++) begin
         @(negedge clk);
         o = observe();
         e = model(k);
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL ms_run k=%0d: actual %s required %s", k, fmt(o), fmt(e));
         end
         if (clk_1ms === 1'b1) hits.push_back(k);
      end
      n_cmp++;
      if (hits.size() != 2) begin
         n_bad++;
         $display("FAIL ms_count: actual %0d pulses required 2", hits.size());
      end else begin
         n_cmp++;
         if (hits[0] != MS - 1 || hits[1] != 2 * MS - 1) begin
            n_bad++;
            $display("FAIL ms_pos: actual %0d,%0d required %0d,%0d",
                     hits[0], hits[1], MS - 1, 2 * MS - 1);
         end
      end
   endtask

   task automatic test_mid_reset();
      snap_t o, e;
      bit    found = 1'b0;
      for (int i = 0; i < 3 * CD * HT * VT && !found; i++) begin
         @(negedge clk);
         if (x == 10'd70 && y == 10'd20) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL mid_reset_wait: actual not reached required x=70 y=20");
         return;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      o = observe();
      n_cmp++;
      if (o !== RST_SNAP) begin
         n_bad++;
         $display("FAIL mid_reset_state: actual %s required %s", fmt(o), fmt(RST_SNAP));
      end
      for (int i = 0; i < CD * HT * VT + CD * HT; i++) begin
         @(negedge clk);
         o = observe();
         e = model(k);
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL after_mid_reset k=%0d: actual %s required %s", k, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_random_resets();
      snap_t o, e;
      int    run_len, rst_len;
      for (int it = 0; it < 5; it++) begin
         run_len = int'($urandom_range(50, 2500));
         rst_len = int'($urandom_range(1, 3));
         for (int i = 0; i < run_len; i++) begin
            @(negedge clk);
            o = observe();
            e = model(k);
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL rand_run%0d k=%0d: actual %s required %s", it, k, fmt(o), fmt(e));
            end
         end
         reset = 1'b1;
         for (int i = 0; i < rst_len; i++) begin
            @(negedge clk);
            o = observe();
            n_cmp++;
            if (o !== RST_SNAP) begin
               n_bad++;
               $display("FAIL rand_reset%0d: actual %s required %s", it, fmt(o), fmt(RST_SNAP));
            end
         end
         reset = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_frame();
      test_ms();
      test_mid_reset();
      test_random_resets();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
